vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen_if
// Brief   : Divider-count input and VGA timing outputs of vga_timing_gen.
// Revision: 1.0
// ============================================================================
interface vga_timing_gen_if;
  logic [23:0] div_count;
  logic        pix_tick;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_tick;

  // Timing generator side
  modport master (
    input  div_count,
    output pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_tick
  );

  // Clock-counter / renderer side
  modport slave (
    output div_count,
    input  pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : 640x480@60 VGA timing driven by one bit of a free-running divider.
//           Define VGA_SYNC_REG_EN to register sync/video/coordinate outputs.
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned PIX_BIT  = 1,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  wire logic        clock,
  input  wire logic        reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  c_HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       r_prev_bit;
  logic       r_pix_tick;
  logic       r_frame_tick;
  logic       r_running;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  logic w_tick_edge;
  logic w_h_last;
  logic w_v_last;
  logic w_hsync;
  logic w_vsync;
  logic w_video_on;

  assign w_tick_edge = bus.div_count[PIX_BIT] & ~r_prev_bit;
  assign w_h_last    = (r_h_cnt == c_H_LAST);
  assign w_v_last    = (r_v_cnt == c_V_LAST);

  // prev_bit resets high so a bit already set at reset release is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_bit   <= 1'b1;
      r_pix_tick   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_running    <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
    end else begin
      r_prev_bit   <= bus.div_count[PIX_BIT];
      r_pix_tick   <= w_tick_edge;
      r_frame_tick <= r_pix_tick & w_h_last & w_v_last;
      if (r_pix_tick) begin
        r_running <= 1'b1;
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  assign w_hsync    = ~((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
  assign w_vsync    = ~((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
  assign w_video_on = r_running && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);

`ifdef VGA_SYNC_REG_EN
  // Extra stage lines the pixel outputs up with a one-cycle sprite ROM read
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [9:0] r_pix_x;
  logic [9:0] r_pix_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
    end else begin
      r_hsync    <= w_hsync;
      r_vsync    <= w_vsync;
      r_video_on <= w_video_on;
      r_pix_x    <= r_h_cnt;
      r_pix_y    <= r_v_cnt;
    end
  end

  assign bus.hsync    = r_hsync;
  assign bus.vsync    = r_vsync;
  assign bus.video_on = r_video_on;
  assign bus.pix_x    = r_pix_x;
  assign bus.pix_y    = r_pix_y;
`else
  assign bus.hsync    = w_hsync;
  assign bus.vsync    = w_vsync;
  assign bus.video_on = w_video_on;
  assign bus.pix_x    = r_h_cnt;
  assign bus.pix_y    = r_v_cnt;
`endif

  assign bus.pix_tick   = r_pix_tick;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Bench for vga_timing_gen: full-size and shrunken-timing instances checked every
// clock against a tick-count model, plus directed line/frame/reset/stall checks.
module tb_vga_timing_gen;

  localparam int c_PB[2]  = '{1, 0};
  localparam int c_HA[2]  = '{640, 16};
  localparam int c_HFP[2] = '{16, 4};
  localparam int c_HS[2]  = '{96, 6};
  localparam int c_HBP[2] = '{48, 4};
  localparam int c_VA[2]  = '{480, 10};
  localparam int c_VFP[2] = '{10, 2};
  localparam int c_VS[2]  = '{2, 2};
  localparam int c_VBP[2] = '{33, 3};
  localparam int c_HT[2]  = '{800, 30};
  localparam int c_VT[2]  = '{525, 17};
`ifdef VGA_SYNC_REG_EN
  localparam int c_OUT_LAT = 1;
`else
  localparam int c_OUT_LAT = 0;
`endif
  localparam logic [22:0] c_RST_DEC = {1'b1, 1'b1, 21'd0};
  localparam logic [24:0] c_RST_OUT = {2'b00, c_RST_DEC};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] dc  = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if u_if0 ();
  vga_timing_gen_if u_if1 ();
  assign u_if0.div_count = dc;
  assign u_if1.div_count = dc;

  vga_timing_gen #(
    .PIX_BIT(c_PB[0]), .H_ACTIVE(c_HA[0]), .H_FP(c_HFP[0]), .H_SYNC(c_HS[0]),
    .H_BP(c_HBP[0]), .V_ACTIVE(c_VA[0]), .V_FP(c_VFP[0]), .V_SYNC(c_VS[0]),
    .V_BP(c_VBP[0])
  ) u_dut0 (.clock(clk), .reset(rst), .bus(u_if0.master));

  vga_timing_gen #(
    .PIX_BIT(c_PB[1]), .H_ACTIVE(c_HA[1]), .H_FP(c_HFP[1]), .H_SYNC(c_HS[1]),
    .H_BP(c_HBP[1]), .V_ACTIVE(c_VA[1]), .V_FP(c_VFP[1]), .V_SYNC(c_VS[1]),
    .V_BP(c_VBP[1])
  ) u_dut1 (.clock(clk), .reset(rst), .bus(u_if1.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: position is simply the number of pixel ticks since reset
  int          m_n[2];
  bit          m_prev[2];
  bit          m_tick[2];
  bit          m_frame[2];
  bit          m_ran[2];
  logic [22:0] m_dly[2];
  bit          m_live   = 0;
  bit          released = 0;
  int          cyc      = 0;

  function automatic logic [22:0] dec(input int d);
    int   h, v;
    logic hs, vs, vo;
    h  = m_n[d] % c_HT[d];
    v  = m_n[d] / c_HT[d];
    hs = !((h >= c_HA[d] + c_HFP[d]) && (h < c_HA[d] + c_HFP[d] + c_HS[d]));
    vs = !((v >= c_VA[d] + c_VFP[d]) && (v < c_VA[d] + c_VFP[d] + c_VS[d]));
    vo = m_ran[d] && (h < c_HA[d]) && (v < c_VA[d]);
    return {hs, vs, vo, v[9:0], h[9:0]};
  endfunction

  function automatic logic [24:0] exp_out(input int d);
`ifdef VGA_SYNC_REG_EN
    return {m_tick[d], m_frame[d], m_dly[d]};
`else
    return {m_tick[d], m_frame[d], dec(d)};
`endif
  endfunction

  function automatic logic [24:0] act(input int d);
    if (d == 0)
      return {u_if0.pix_tick, u_if0.frame_tick, u_if0.hsync, u_if0.vsync,
              u_if0.video_on, u_if0.pix_y, u_if0.pix_x};
    return {u_if1.pix_tick, u_if1.frame_tick, u_if1.hsync, u_if1.vsync,
            u_if1.video_on, u_if1.pix_y, u_if1.pix_x};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_n[d] = 0; m_prev[d] = 1'b1; m_tick[d] = 1'b0;
        m_frame[d] = 1'b0; m_ran[d] = 1'b0; m_dly[d] = c_RST_DEC;
      end else begin
        m_dly[d]   = dec(d);
        m_frame[d] = m_tick[d] && (m_n[d] == c_HT[d] * c_VT[d] - 1);
        if (m_tick[d]) begin
          m_n[d]   = (m_n[d] + 1) % (c_HT[d] * c_VT[d]);
          m_ran[d] = 1'b1;
        end
        m_tick[d] = dc[c_PB[d]] && !m_prev[d];
        m_prev[d] = dc[c_PB[d]];
      end
    end
    m_live = 1'b1;
    if (!rst) released = 1'b1;
    if (released) cyc++;
  end

  // Directed measurements taken during the first free-running stretch
  bit   mon_en = 0;
  int   tk0 = 0, first_tick_cyc = -1, t656_cyc = -1;
  int   hs_fall_cyc = -1, hs_fall_x = -1, hs_low = 0;
  bit   hs_prev = 1'b1, hs_done = 1'b0;
  int   vs_low = 0;
  bit   vs_prev = 1'b1, vs_seen = 1'b0, vs_done = 1'b0;
  int   fr_rise = 0, fr_high = 0;
  bit   fr_prev = 1'b0;
  logic vo_c2 = 1'bx, vo_c6 = 1'bx;
  int   x_c3202 = -1, y_c3202 = -1;

  always @(negedge clk) begin
    if (m_live) begin
      chk("dut0_outs", 32'(act(0)), 32'(exp_out(0)));
      chk("dut1_outs", 32'(act(1)), 32'(exp_out(1)));
    end
    if (mon_en) begin
      if (u_if0.pix_tick) begin
        tk0++;
        if (first_tick_cyc < 0) first_tick_cyc = cyc;
        if (tk0 == 656) t656_cyc = cyc;
      end
      if (!u_if0.hsync && hs_prev && hs_fall_cyc < 0) begin
        hs_fall_cyc = cyc;
        hs_fall_x   = int'(u_if0.pix_x);
      end
      if (hs_fall_cyc >= 0 && !hs_done) begin
        if (!u_if0.hsync) hs_low++; else hs_done = 1'b1;
      end
      hs_prev = u_if0.hsync;
      if (cyc == 2) vo_c2 = u_if0.video_on;
      if (cyc == 6) vo_c6 = u_if0.video_on;
      if (cyc == 3202) begin
        x_c3202 = int'(u_if0.pix_x);
        y_c3202 = int'(u_if0.pix_y);
      end
      if (!u_if1.vsync && vs_prev) vs_seen = 1'b1;
      if (vs_seen && !vs_done) begin
        if (!u_if1.vsync) vs_low++; else vs_done = 1'b1;
      end
      vs_prev = u_if1.vsync;
      if (cyc <= 1100) begin
        if (u_if1.frame_tick) fr_high++;
        if (u_if1.frame_tick && !fr_prev) fr_rise++;
      end
      fr_prev = u_if1.frame_tick;
    end
  end

  initial begin
    int guard, ticks, ex0, ey0, ex1, ey1, r;
    rst = 1'b1;
    dc  = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state0", 32'(act(0)), 32'(c_RST_OUT));
    chk("rst_state1", 32'(act(1)), 32'(c_RST_OUT));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    dc     = '0;
    mon_en = 1'b1;
    repeat (3300) begin
      @(negedge clk);
      dc = dc + 24'd1;
    end
    mon_en = 1'b0;

    chk("first_tick_cyc", first_tick_cyc, 3);
    chk("vo_before_tick", 32'(vo_c2), 0);
    chk("vo_after_tick", 32'(vo_c6), 1);
    chk("hs_fall_x", hs_fall_x, c_HA[0] + c_HFP[0]);
    chk("hs_low_clks", hs_low, c_HS[0] * 4);
    chk("hs_fall_lag", hs_fall_cyc - t656_cyc, 1 + c_OUT_LAT);
    chk("line1_x", x_c3202, 0);
    chk("line1_y", y_c3202, 1);
    chk("vs_low_clks", vs_low, c_VS[1] * c_HT[1] * 2);
    chk("frame_pulses", fr_rise, 1);
    chk("frame_width", fr_high, 1);

    // Random divider behaviour: steps, stalls, jumps, rollover, stray resets
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      r   = $urandom_range(0, 999);
      rst = (r < 2);
      r   = $urandom_range(0, 99);
      if (i == 15000)  dc = 24'hFFFFF0;
      else if (r < 70) dc = dc + 24'd1;
      else if (r < 85) dc = dc;
      else if (r < 97) dc = dc + 24'($urandom_range(2, 7));
      else             dc = 24'($urandom);
    end

    // Reset mid-frame, landing on a cycle where the small instance ticks
    @(negedge clk);
    rst   = 1'b0;
    guard = 0;
    while (!(m_tick[1] && m_n[1] >= 5 * c_HT[1]) && guard < 5000) begin
      @(negedge clk);
      dc = dc + 24'd1;
      guard++;
    end
    chk("mid_reached", 32'(guard < 5000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst0", 32'(act(0)), 32'(c_RST_OUT));
    chk("mid_rst1", 32'(act(1)), 32'(c_RST_OUT));
    rst = 1'b0;

    repeat (200) begin
      @(negedge clk);
      dc = dc + 24'd1;
    end

    // Stalled divider: no ticks, coordinates frozen
    dc = 24'h000002;
    repeat (4) @(negedge clk);
    ex0 = m_n[0] % c_HT[0]; ey0 = m_n[0] / c_HT[0];
    ex1 = m_n[1] % c_HT[1]; ey1 = m_n[1] / c_HT[1];
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (u_if0.pix_tick) ticks++;
      if (u_if1.pix_tick) ticks++;
    end
    chk("stall_ticks", ticks, 0);
    chk("stall_x0", 32'(u_if0.pix_x), ex0);
    chk("stall_y0", 32'(u_if0.pix_y), ey0);
    chk("stall_x1", 32'(u_if1.pix_x), ex1);
    chk("stall_y1", 32'(u_if1.pix_y), ey1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
